// File: rtl/dso_spi_regbus_pkg.sv
// Shared definitions for the DSO SPI register bridge: command-byte field positions
// and the frame state encoding.
package dso_spi_regbus_pkg;

  localparam int CMD_WR_BIT   = 7;
  localparam int CMD_ADDR_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/dso_spi_regbus_sync_edge.sv
// Synchroniser for one asynchronous input plus registered one-clk rise/fall pulses,
// taken from the synchronised level.
module dso_spi_regbus_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic nrst,
  input  logic din,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  // NOTE: every flop here uses <= so all stages shift on the same edge; a blocking
  // assignment would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      chain <= '0;
      prev  <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      prev  <= chain[SYNC_STAGES-1];
      rise  <= chain[SYNC_STAGES-1] & ~prev;
      fall  <= ~chain[SYNC_STAGES-1] & prev;
    end
  end

endmodule

// File: rtl/dso_spi_regbus.sv
// SPI mode-0 slave bridging host frames (command byte + data byte) onto the
// 8x8 DSO register file. Define DSO_SPI_AUTOINC_EN for burst access with address auto-increment.
module dso_spi_regbus
  import dso_spi_regbus_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 3,
  parameter int DATA_W      = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              spi_ncs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              reg_we,
  input  logic [DATA_W-1:0] reg_rdata
);

  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);

  logic sck_rise, sck_fall, ncs_rise, ncs_fall;

  dso_spi_regbus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck (
    .clk(clk), .nrst(nrst), .din(spi_sck), .rise(sck_rise), .fall(sck_fall)
  );

  dso_spi_regbus_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ncs (
    .clk(clk), .nrst(nrst), .din(spi_ncs), .rise(ncs_rise), .fall(ncs_fall)
  );

  // The extra mosi_d stage matches the edge-pulse register, so the bit sampled on a
  // detected rise is the one the synchroniser saw together with that sck edge.
  logic [SYNC_STAGES-1:0] mosi_chain;
  logic                   mosi_d;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mosi_chain <= '0;
      mosi_d     <= 1'b0;
    end else begin
      mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], spi_mosi};
      mosi_d     <= mosi_chain[SYNC_STAGES-1];
    end
  end

  state_t            state, state_next;
  logic [2:0]        bit_cnt;
  logic [DATA_W-1:0] shift_in, tx, byte_next;
  logic              is_wr, load_pend, byte_done;
`ifdef DSO_SPI_AUTOINC_EN
  logic              inc_pend;
`endif

  assign byte_next = {shift_in[DATA_W-2:0], mosi_d};
  assign byte_done = sck_rise && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: state_next gets its default before the case, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_next = state;
    if (ncs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (ncs_fall) state_next = CMD;
        CMD:  if (byte_done) state_next = DATA;
        DATA: begin
`ifdef DSO_SPI_AUTOINC_EN
          state_next = DATA;
`else
          if (byte_done) state_next = DONE;
`endif
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      bit_cnt     <= '0;
      shift_in    <= '0;
      tx          <= '0;
      is_wr       <= 1'b0;
      load_pend   <= 1'b0;
      reg_addr    <= '0;
      reg_wdata   <= '0;
      reg_we      <= 1'b0;
      spi_miso    <= 1'b0;
      spi_miso_oe <= 1'b0;
`ifdef DSO_SPI_AUTOINC_EN
      inc_pend    <= 1'b0;
`endif
    end else begin
      reg_we    <= 1'b0;
      load_pend <= 1'b0;
`ifdef DSO_SPI_AUTOINC_EN
      inc_pend  <= 1'b0;
`endif
      if (ncs_rise) begin
        // Frame end or abort: any partial byte is dropped and the pad released.
        bit_cnt     <= '0;
        spi_miso    <= 1'b0;
        spi_miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (ncs_fall) begin
              bit_cnt     <= '0;
              spi_miso    <= 1'b0;
              spi_miso_oe <= 1'b1;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift_in <= byte_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) begin
                reg_addr  <= byte_next[CMD_ADDR_LSB +: ADDR_W];
                is_wr     <= byte_next[CMD_WR_BIT];
                load_pend <= ~byte_next[CMD_WR_BIT];
              end
            end
          end
          DATA: begin
            if (load_pend) begin
              tx <= reg_rdata;
            end else if (sck_fall && !is_wr) begin
              spi_miso <= tx[DATA_W-1];
              tx       <= {tx[DATA_W-2:0], 1'b0};
            end
`ifdef DSO_SPI_AUTOINC_EN
            if (inc_pend) reg_addr <= reg_addr + ADDR_W'(1);
`endif
            if (sck_rise) begin
              shift_in <= byte_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == BIT_LAST) begin
                if (is_wr) begin
                  reg_wdata <= byte_next;
                  reg_we    <= 1'b1;
`ifdef DSO_SPI_AUTOINC_EN
                  inc_pend  <= 1'b1;
`endif
                end else begin
`ifdef DSO_SPI_AUTOINC_EN
                  reg_addr  <= reg_addr + ADDR_W'(1);
                  load_pend <= 1'b1;
`endif
                end
              end
            end
          end
          default: spi_miso <= 1'b0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dso_spi_regbus.sv
// Scoreboard bench for dso_spi_regbus: SPI master stimulus pushes expected register
// writes and read bytes; independent monitors pop and compare.
module tb_dso_spi_regbus;
  import dso_spi_regbus_pkg::*;

  localparam int HALF = 60;

  typedef struct {
    logic [2:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk = 1'b0;
  logic       nrst;
  logic       spi_ncs, spi_sck, spi_mosi;
  logic       spi_miso, spi_miso_oe;
  logic [2:0] reg_addr;
  logic [7:0] reg_wdata, reg_rdata;
  logic       reg_we;

  logic [7:0] mem [8];

  int checks   = 0;
  int failures = 0;

  wr_t        wr_q   [$];
  logic [7:0] rd_exp [$];
  logic [7:0] rd_obs [$];
  logic [7:0] fr     [$];

  dso_spi_regbus dut (
    .clk(clk), .nrst(nrst),
    .spi_ncs(spi_ncs), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we),
    .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  // Register-file model: combinational read, write on the strobe.
  assign reg_rdata = mem[reg_addr];

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < 8; i++) mem[i] <= {1'b0, 3'(i), 1'b0, 3'(i)};
      mem[5] <= 8'hC3;
    end else if (reg_we) begin
      mem[reg_addr] <= reg_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every strobe must match the oldest expected write.
  initial begin
    forever begin
      @(negedge clk);
      if (reg_we === 1'b1) begin
        if (wr_q.size() == 0) begin
          check("we_unexpected", wr_q.size(), 1);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          check("wr_addr", reg_addr, e.addr);
          check("wr_data", reg_wdata, e.data);
        end
      end
    end
  end

  // Read monitor: bytes captured by the master against expected read data.
  initial begin
    forever begin
      logic [7:0] r;
      wait (rd_obs.size() != 0);
      r = rd_obs.pop_front();
      if (rd_exp.size() == 0) check("rd_unexpected", rd_exp.size(), 1);
      else                    check("rd_byte", r, rd_exp.pop_front());
    end
  end

  task automatic spi_byte(input logic [7:0] b, input int nbits, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      #(HALF);
      spi_sck  = 1'b1;
      r[7-i]   = spi_miso;
      #(HALF);
      spi_sck  = 1'b0;
    end
  endtask

  // Sends fr[]; abort_bits>0 truncates the last byte. Read frames push every byte after the command.
  task automatic spi_frame(input int abort_bits, input bit is_read);
    logic [7:0] r;
    spi_ncs = 1'b0;
    #(HALF);
    check("oe_in_frame", spi_miso_oe, 1);
    for (int k = 0; k < fr.size(); k++) begin
      spi_byte(fr[k], (k == fr.size() - 1 && abort_bits > 0) ? abort_bits : 8, r);
      if (is_read && k > 0) rd_obs.push_back(r);
    end
    #(HALF);
    spi_ncs = 1'b1;
    #(3 * HALF);
    check("oe_after_frame", spi_miso_oe, 0);
    check("miso_after_frame", spi_miso, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, reg_we, 0);
    check({tag, "_addr"}, reg_addr, 0);
    check({tag, "_wdata"}, reg_wdata, 0);
    check({tag, "_miso"}, spi_miso, 0);
    check({tag, "_oe"}, spi_miso_oe, 0);
  endtask

  initial begin
    logic [7:0] r;
    spi_ncs  = 1'b1;
    spi_sck  = 1'b0;
    spi_mosi = 1'b0;
    nrst     = 1'b1;
    #2 nrst  = 1'b0;
    #31;
    check_reset_outputs("rst");
    check("rst_state", dut.state, IDLE);
    nrst = 1'b1;
    #(2 * HALF + 3);

    // 1: single write to address 3.
    wr_q.push_back('{3'd3, 8'h5A});
    fr = '{8'h83, 8'h5A};
    spi_frame(0, 1'b0);

    // 2: read of address 5, expected C3 (bits 1,1,0,0,0,0,1,1).
    rd_exp.push_back(8'hC3);
    fr = '{8'h05, 8'h00};
    spi_frame(0, 1'b1);

    // 3: write aborted after 5 data bits.
    fr = '{8'h82, 8'hFF};
    spi_frame(5, 1'b0);
    check("abort_state", dut.state, IDLE);

    // 4: reset pulsed during the command byte, then a clean write to address 1.
    spi_ncs = 1'b0;
    #(HALF);
    spi_byte(8'h85, 4, r);
    #7 nrst = 1'b0;
    #25;
    check_reset_outputs("midrst");
    nrst = 1'b1;
    #(HALF);
    spi_ncs = 1'b1;
    #(3 * HALF);
    check("midrst_state", dut.state, IDLE);
    wr_q.push_back('{3'd1, 8'h11});
    fr = '{8'h81, 8'h11};
    spi_frame(0, 1'b0);

    // 5: reserved command bits ignored.
    wr_q.push_back('{3'd1, 8'h22});
    fr = '{8'hF9, 8'h22};
    spi_frame(0, 1'b0);

    // 6: burst write starting at 7, wrapping to 0 and 1.
    wr_q.push_back('{3'd7, 8'hA1});
`ifdef DSO_SPI_AUTOINC_EN
    wr_q.push_back('{3'd0, 8'hB2});
    wr_q.push_back('{3'd1, 8'hC3});
`endif
    fr = '{8'h87, 8'hA1, 8'hB2, 8'hC3};
    spi_frame(0, 1'b0);

    // Burst read of 6 then 7 (now A1); without burst the second byte reads as zero.
    rd_exp.push_back(8'h66);
`ifdef DSO_SPI_AUTOINC_EN
    rd_exp.push_back(8'hA1);
`else
    rd_exp.push_back(8'h00);
`endif
    fr = '{8'h06, 8'h00, 8'h00};
    spi_frame(0, 1'b1);

    for (int i = 0; i < 1000 && (wr_q.size() != 0 || rd_exp.size() != 0); i++) @(negedge clk);
    check("wr_q_drained", wr_q.size(), 0);
    check("rd_q_drained", rd_exp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
